// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
//   Shared types and constants for the FIFO read-side drain stage:
//     rd_state_e : control state (RUN / PAUSE / FLUSH)
//     BUF_DEPTH  : depth of the output buffer (2 entries)
//     occ_t      : buffer occupancy (0..2)
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_e;

  localparam int unsigned BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = occ_t'(0);
  localparam occ_t OCC_ONE   = occ_t'(1);
  localparam occ_t OCC_FULL  = occ_t'(BUF_DEPTH);

endpackage

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
//   Two-entry in-order buffer (head/tail registers plus occupancy count).
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     push, push_data    : write a word into the tail (ignored when full)
//     retire             : drop the head word (ignored when empty)
//     clear              : invalidate both entries (wins over push/retire)
//     head_data          : oldest buffered word (registered)
//     head_valid         : buffer is non-empty
//     cnt                : current occupancy, 0..2
// -----------------------------------------------------------------------------
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [DATA-1:0] push_data,
  input  logic            retire,
  input  logic            clear,
  output logic [DATA-1:0] head_data,
  output logic            head_valid,
  output occ_t            cnt
);

  logic [DATA-1:0] head_q, head_d;
  logic [DATA-1:0] tail_q, tail_d;
  occ_t            cnt_q, cnt_d;
  logic            push_ok;
  logic            retire_ok;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    push_ok   = push && (cnt_q < OCC_FULL);
    retire_ok = retire && (cnt_q != OCC_EMPTY);

    if (clear) begin
      cnt_d = OCC_EMPTY;
    end else begin
      case (cnt_q)
        OCC_EMPTY: begin
          if (push_ok) begin
            head_d = push_data;
            cnt_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push_ok && retire_ok) begin
            // Head leaves while the new word arrives: it becomes the head
            // directly, occupancy stays at one.
            head_d = push_data;
          end else if (push_ok) begin
            tail_d = push_data;
            cnt_d  = OCC_FULL;
          end else if (retire_ok) begin
            cnt_d = OCC_EMPTY;
          end
        end
        default: begin
          // Full: only a retire can happen; tail shifts into the head.
          if (retire_ok) begin
            head_d = tail_q;
            cnt_d  = OCC_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= OCC_EMPTY;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = (cnt_q != OCC_EMPTY);
  assign cnt        = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//   Read-domain drain stage behind an asynchronous FIFO. Pops the FIFO and
//   presents the words on a valid/ready stream through a 2-entry buffer, at
//   up to one word per cycle. r_en depends only on registered state, the
//   buffer count and r_empty, so m_ready never reaches the FIFO combinationally.
//   Ports:
//     r_clk, r_rst_n   : read clock, asynchronous active-low reset
//     r_empty, rdata   : FIFO empty flag and current read word
//     r_en             : FIFO pop request
//     pause            : stop popping (buffered words still drain)
//     flush            : discard buffered words, drain FIFO silently
//     m_valid, m_ready : output stream handshake
//     m_data           : output stream word
//     beat_cnt         : accepted-beat counter (only with FIFO_RD_STATS_EN)
//   Build option:
//     FIFO_RD_STATS_EN : adds the beat_cnt port and its counter register.
// -----------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA  = 128,
  parameter int unsigned CNT_W = 32
) (
  input  logic             r_clk,
  input  logic             r_rst_n,
  input  logic             r_empty,
  input  logic [DATA-1:0]  rdata,
  output logic             r_en,
  input  logic             pause,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DATA-1:0]  m_data
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0] beat_cnt
`endif
);

  rd_state_e       state_q, state_d;
  logic            alive_q, alive_d;
  occ_t            buf_cnt;
  logic            buf_valid;
  logic [DATA-1:0] buf_head;
  logic            pop;
  logic            push;
  logic            retire;
  logic            clear;

  // ---------------------------------------------------------------------------
  // Control state: flush > pause > run, re-evaluated every cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = ST_RUN;
    if (flush) begin
      state_d = ST_FLUSH;
    end else if (pause) begin
      state_d = ST_PAUSE;
    end
  end

  // alive_q is low while reset is asserted (and for the first cycle after),
  // so r_en drops immediately on an asynchronous reset even though it is
  // otherwise decoded from r_empty, which does not depend on our reset.
  assign alive_d = 1'b1;

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state_q <= ST_RUN;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pop / push / retire decode
  // ---------------------------------------------------------------------------
  always_comb begin
    pop = 1'b0;
    if (alive_q) begin
      case (state_q)
        ST_RUN:   pop = !r_empty && (buf_cnt < OCC_FULL);
        ST_FLUSH: pop = !r_empty;
        default:  pop = 1'b0;
      endcase
    end
  end

  // Words popped while flushing are dropped; only RUN pops enter the buffer.
  assign push    = pop && (state_q == ST_RUN);
  assign clear   = (state_q == ST_FLUSH);
  assign m_valid = buf_valid && (state_q != ST_FLUSH);
  assign retire  = m_valid && m_ready;
  assign r_en    = pop;
  assign m_data  = buf_head;

  fifo_rd_skid #(
    .DATA (DATA)
  ) u_skid (
    .clk        (r_clk),
    .rst_n      (r_rst_n),
    .push       (push),
    .push_data  (rdata),
    .retire     (retire),
    .clear      (clear),
    .head_data  (buf_head),
    .head_valid (buf_valid),
    .cnt        (buf_cnt)
  );

  // ---------------------------------------------------------------------------
  // Optional accepted-beat counter. m_valid is already low in FLUSH, so the
  // counter naturally holds there. Wraps modulo 2^CNT_W.
  // ---------------------------------------------------------------------------
`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (retire) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  // Counter absent; this keeps CNT_W referenced so the parameter list is the
  // same in both builds.
  logic [CNT_W-1:0] unused_beat_cnt;
  assign unused_beat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//   Directed bench for fifo_rd_stream: a per-cycle vector table covering
//   basic transfer, backpressure, pause and flush, followed by hand-written
//   sequences for streaming, long backpressure, pause, flush and async reset.
//   The FIFO is modelled by a queue (r_empty/rdata follow its head).
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int DATA  = 128;
  localparam int CNT_W = 32;

  logic             r_clk   = 1'b0;
  logic             r_rst_n = 1'b0;
  logic             r_empty = 1'b1;
  logic [DATA-1:0]  rdata   = '0;
  logic             r_en;
  logic             pause   = 1'b0;
  logic             flush   = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DATA-1:0]  m_data;
`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] beat_cnt;
`endif

  fifo_rd_stream #(
    .DATA  (DATA),
    .CNT_W (CNT_W)
  ) dut (
    .r_clk    (r_clk),
    .r_rst_n  (r_rst_n),
    .r_empty  (r_empty),
    .rdata    (rdata),
    .r_en     (r_en),
    .pause    (pause),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data)
`ifdef FIFO_RD_STATS_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  always #5 r_clk = ~r_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA-1:0] fifo_q[$];

  function automatic void refresh();
    r_empty = (fifo_q.size() == 0);
    rdata   = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endfunction

  task automatic chk(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic push_word(input logic [DATA-1:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // FIFO model: sample r_en at the edge, apply the pop just after it.
  initial begin
    forever begin
      logic pop_now;
      @(posedge r_clk);
      pop_now = r_en;
      #1;
      if (pop_now) begin
        if (fifo_q.size() == 0) begin
          chk("underflow_pop", {{(DATA-1){1'b0}}, r_empty}, '0);
        end else begin
          void'(fifo_q.pop_front());
        end
      end
      refresh();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       p;
    logic       f;
    logic       rdy;
    int         push_n;
    logic [7:0] push_base;
    logic       exp_ren;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic p, input logic f, input logic rdy, input int n,
                     input logic [7:0] base, input logic ren, input logic v, input logic [7:0] d);
    vec_t e;
    e.p = p; e.f = f; e.rdy = rdy; e.push_n = n; e.push_base = base;
    e.exp_ren = ren; e.exp_valid = v; e.exp_data = d;
    vq.push_back(e);
  endtask

  // Collect n in-order words starting at index idx; caller sits mid-cycle.
  task automatic collect(input string name, input logic [7:0] base, inout int idx, input int n);
    for (int cyc = 0; cyc < 60 && idx < n; cyc++) begin
      if (m_valid && m_ready) begin
        chk(name, m_data, DATA'(base) + DATA'(idx));
        idx++;
      end
      @(negedge r_clk); #1;
    end
    chk({name, "_count"}, DATA'(idx), DATA'(n));
  endtask

  initial begin
    int idx;
    bit seen;

    // ---------------- reset state ----------------
    refresh();
    @(negedge r_clk); @(negedge r_clk); #1;
    chk("rst_r_en", DATA'(r_en), '0);
    chk("rst_m_valid", DATA'(m_valid), '0);
    chk("rst_m_data", m_data, '0);
`ifdef FIFO_RD_STATS_EN
    chk("rst_beat_cnt", DATA'(beat_cnt), '0);
`endif
    @(negedge r_clk); r_rst_n = 1'b1;
    @(posedge r_clk);

    // ---------------- vector table ----------------
    //   p  f  rdy n  base   ren v  data
    add(0, 0, 1, 1, 8'hA1, 1, 0, 8'h00);  // basic: pop the first cycle non-empty
    add(0, 0, 1, 0, 8'h00, 0, 1, 8'hA1);  // one cycle later on m_data
    add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00);  // retired, buffer empty
    add(0, 0, 0, 3, 8'hB0, 1, 0, 8'h00);  // backpressure: 3 words
    add(0, 0, 0, 0, 8'h00, 1, 1, 8'hB0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 8'hB0);  // cnt=2, r_en low
    add(0, 0, 1, 0, 8'h00, 0, 1, 8'hB0);
    add(0, 0, 1, 0, 8'h00, 1, 1, 8'hB1);
    add(0, 0, 1, 0, 8'h00, 0, 1, 8'hB2);
    add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 0, 0, 2, 8'hC0, 1, 0, 8'h00);  // pause sampled: r_en still high this cycle
    add(1, 0, 0, 0, 8'h00, 0, 1, 8'hC0);
    add(1, 0, 1, 0, 8'h00, 0, 1, 8'hC0);  // buffered word drains while paused
    add(1, 0, 1, 0, 8'h00, 0, 0, 8'h00);
    add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00);  // release: state still PAUSE this cycle
    add(0, 0, 1, 0, 8'h00, 1, 0, 8'h00);
    add(0, 0, 1, 0, 8'h00, 0, 1, 8'hC1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00);
    add(0, 0, 0, 3, 8'hD0, 1, 0, 8'h00);  // flush: 3 words, one buffered
    add(0, 1, 0, 0, 8'h00, 1, 1, 8'hD0);
    add(0, 1, 0, 0, 8'h00, 1, 0, 8'h00);  // FLUSH: m_valid low, last word dropped
    add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00);
    add(0, 0, 1, 1, 8'hE5, 1, 0, 8'h00);
    add(0, 0, 1, 0, 8'h00, 0, 1, 8'hE5);  // first word after flush
    add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00);

    foreach (vq[i]) begin
      @(negedge r_clk);
      pause   = vq[i].p;
      flush   = vq[i].f;
      m_ready = vq[i].rdy;
      for (int k = 0; k < vq[i].push_n; k++) push_word(DATA'(vq[i].push_base) + DATA'(k));
      #1;
      chk($sformatf("vec%0d_r_en", i), DATA'(r_en), DATA'(vq[i].exp_ren));
      chk($sformatf("vec%0d_m_valid", i), DATA'(m_valid), DATA'(vq[i].exp_valid));
      if (vq[i].exp_valid) chk($sformatf("vec%0d_m_data", i), m_data, DATA'(vq[i].exp_data));
    end
`ifdef FIFO_RD_STATS_EN
    chk("table_beat_cnt", DATA'(beat_cnt), DATA'(7));
`endif

    // ---------------- streaming 16 words ----------------
    @(negedge r_clk);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(DATA'(i));
    #1;
    chk("stream_r_en", DATA'(r_en), DATA'(1));
    for (int i = 0; i < 16; i++) begin
      @(negedge r_clk); #1;
      chk("stream_valid", DATA'(m_valid), DATA'(1));
      chk("stream_data", m_data, DATA'(i));
    end
    @(negedge r_clk); #1;
    chk("stream_done_valid", DATA'(m_valid), '0);
`ifdef FIFO_RD_STATS_EN
    chk("stream_beat_cnt", DATA'(beat_cnt), DATA'(23));
`endif

    // ---------------- backpressure: 8 words, 10 cycles held ----------------
    @(negedge r_clk);
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(DATA'(8'h20 + i));
    for (int k = 0; k < 10; k++) begin
      @(negedge r_clk); #1;
      if (k >= 1) begin
        chk("bp_r_en", DATA'(r_en), '0);
        chk("bp_valid", DATA'(m_valid), DATA'(1));
        chk("bp_data", m_data, DATA'(8'h20));
      end
    end
    m_ready = 1'b1;
    idx = 0;
    collect("bp_out", 8'h20, idx, 8);
`ifdef FIFO_RD_STATS_EN
    chk("bp_beat_cnt", DATA'(beat_cnt), DATA'(31));
`endif

    // ---------------- pause with 2 buffered, 5 in FIFO ----------------
    @(negedge r_clk);
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_word(DATA'(8'h60 + i));
    @(negedge r_clk); @(negedge r_clk); #1;
    chk("pause_pre_r_en", DATA'(r_en), '0);
    pause   = 1'b1;
    m_ready = 1'b1;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      if (m_valid && m_ready) begin
        chk("pause_drain", m_data, DATA'(8'h60) + DATA'(idx));
        idx++;
      end
      @(negedge r_clk); #1;
      chk("pause_r_en", DATA'(r_en), '0);
    end
    chk("pause_drained", DATA'(idx), DATA'(2));
    pause = 1'b0;
    collect("pause_out", 8'h60, idx, 7);
`ifdef FIFO_RD_STATS_EN
    chk("pause_beat_cnt", DATA'(beat_cnt), DATA'(38));
`endif

    // ---------------- flush 12 cycles, 2 buffered, 6 in FIFO ----------------
    @(negedge r_clk);
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(DATA'(8'h40 + i));
    @(negedge r_clk); @(negedge r_clk); #1;
    chk("flush_pre_valid", DATA'(m_valid), DATA'(1));
    chk("flush_pre_data", m_data, DATA'(8'h40));
    flush = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge r_clk); #1;
      chk("flush_valid", DATA'(m_valid), '0);
      if (k == 11) flush = 1'b0;
    end
    chk("flush_fifo_empty", DATA'(r_empty), DATA'(1));
`ifdef FIFO_RD_STATS_EN
    chk("flush_beat_cnt", DATA'(beat_cnt), DATA'(38));
`endif
    @(negedge r_clk);
    m_ready = 1'b1;
    push_word(DATA'(8'h55));
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge r_clk); #1;
      if (m_valid) seen = 1'b1;
    end
    chk("post_flush_seen", DATA'(seen), DATA'(1));
    chk("post_flush_data", m_data, DATA'(8'h55));
    @(negedge r_clk); #1;
`ifdef FIFO_RD_STATS_EN
    chk("post_flush_beat_cnt", DATA'(beat_cnt), DATA'(39));
`endif

    // ---------------- asynchronous reset mid-stream ----------------
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(DATA'(8'h70 + i));
    @(negedge r_clk); @(negedge r_clk); #2;
    r_rst_n = 1'b0;
    #1;
    chk("arst_r_en", DATA'(r_en), '0);
    chk("arst_m_valid", DATA'(m_valid), '0);
    chk("arst_m_data", m_data, '0);
`ifdef FIFO_RD_STATS_EN
    chk("arst_beat_cnt", DATA'(beat_cnt), '0);
`endif
    fifo_q.delete();
    refresh();
    @(negedge r_clk);
    r_rst_n = 1'b1;
    @(negedge r_clk); #1;
    chk("post_rst_valid", DATA'(m_valid), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
